arb_req_ctrl: RTL and testbench

ARB_REQ_CTRL -- requirements
Module: arb_req_ctrl

---
 rtl/arb_req_ctrl_if.sv | 43 ++++
 rtl/arb_req_ctrl.sv | 174 +++++++++++++++++
 tb/tb_arb_req_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_req_ctrl_if.sv
// Request-controller bus: start/length/grant inputs and the request,
// completion and status outputs of the 4-agent arbiter request controller.
//   start        : per-agent transfer-request pulse
//   len_0..len_3 : burst length in grant beats per agent (0 means 1)
//   gnt_0..gnt_3 : grants from the downstream arbiter
//   req_0..req_3 : registered requests to the arbiter
//   done         : one-cycle completion pulse per agent
//   busy         : agent not idle
//   ovf/tmo/spur : sticky overflow / grant-timeout / spurious-grant flags
interface arb_req_ctrl_if;
    logic [3:0] start;
    logic [3:0] len_0;
    logic [3:0] len_1;
    logic [3:0] len_2;
    logic [3:0] len_3;
    logic       gnt_0;
    logic       gnt_1;
    logic       gnt_2;
    logic       gnt_3;
    logic       req_0;
    logic       req_1;
    logic       req_2;
    logic       req_3;
    logic [3:0] done;
    logic [3:0] busy;
    logic [3:0] ovf;
    logic [3:0] tmo;
    logic [3:0] spur;

    modport master (
        output start, len_0, len_1, len_2, len_3,
        output gnt_0, gnt_1, gnt_2, gnt_3,
        input  req_0, req_1, req_2, req_3,
        input  done, busy, ovf, tmo, spur
    );

    modport slave (
        input  start, len_0, len_1, len_2, len_3,
        input  gnt_0, gnt_1, gnt_2, gnt_3,
        output req_0, req_1, req_2, req_3,
        output done, busy, ovf, tmo, spur
    );
endinterface

// File: rtl/arb_req_ctrl.sv
// Four independent request controllers sitting in front of a 4-agent
// arbiter. Each agent runs IDLE -> REQ -> XFER -> REL, counting granted
// beats of a burst, with a one-deep pending slot for a follow-on start.
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : arb_req_ctrl_if.slave (start, len_*, gnt_* in; req_*, done,
//           busy, ovf, tmo, spur out)
// WAIT_LIMIT: ungranted REQ cycles after which the agent's tmo flag sets.
module arb_req_ctrl #(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input logic           clock,
    input logic           reset,
    arb_req_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_REL
    } state_e;

    state_e     state_q    [4];
    state_e     state_d    [4];
    logic [3:0] cnt_q      [4];
    logic [3:0] cnt_d      [4];
    logic [7:0] wait_q     [4];
    logic [7:0] wait_d     [4];
    logic [7:0] wait_inc   [4];
    logic [3:0] pend_len_q [4];
    logic [3:0] pend_len_d [4];
    logic [3:0] len_eff    [4];
    logic [3:0] pend_v_q, pend_v_d;
    logic [3:0] req_q,    req_d;
    logic [3:0] done_q,   done_d;
    logic [3:0] ovf_q,    ovf_d;
    logic [3:0] tmo_q,    tmo_d;
    logic [3:0] spur_q,   spur_d;
    logic [3:0] gnt;
    logic [3:0] rel_exit;

    // Input gathering, effective length, saturating wait increment.
    always_comb begin
        gnt        = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
        len_eff[0] = (bus.len_0 == 4'd0) ? 4'd1 : bus.len_0;
        len_eff[1] = (bus.len_1 == 4'd0) ? 4'd1 : bus.len_1;
        len_eff[2] = (bus.len_2 == 4'd0) ? 4'd1 : bus.len_2;
        len_eff[3] = (bus.len_3 == 4'd0) ? 4'd1 : bus.len_3;
        rel_exit   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wait_inc[i] = (wait_q[i] == 8'hFF) ? 8'hFF : wait_q[i] + 8'd1;
            rel_exit[i] = (state_q[i] == S_REL) && !gnt[i];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i]    <= S_IDLE;
                cnt_q[i]      <= '0;
                wait_q[i]     <= '0;
                pend_len_q[i] <= '0;
            end
            pend_v_q <= '0;
            req_q    <= '0;
            done_q   <= '0;
            ovf_q    <= '0;
            tmo_q    <= '0;
            spur_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i]    <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
                wait_q[i]     <= wait_d[i];
                pend_len_q[i] <= pend_len_d[i];
            end
            pend_v_q <= pend_v_d;
            req_q    <= req_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            spur_q   <= spur_d;
        end
    end

    // Next-state logic.
    always_comb begin
        pend_v_d = pend_v_q;
        req_d    = '0;
        done_d   = '0;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        spur_d   = spur_q;
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            wait_d[i]     = wait_q[i];
            pend_len_d[i] = pend_len_q[i];

            unique case (state_q[i])
                S_IDLE: begin
                    if (gnt[i]) spur_d[i] = 1'b1;
                    if (bus.start[i]) begin
                        state_d[i] = S_REQ;
                        cnt_d[i]   = len_eff[i];
                        wait_d[i]  = '0;
                    end
                end
                S_REQ, S_XFER: begin
                    if (gnt[i]) begin
                        if (cnt_q[i] == 4'd1) begin
                            state_d[i] = S_REL;
                        end else begin
                            cnt_d[i]   = cnt_q[i] - 4'd1;
                            state_d[i] = S_XFER;
                        end
                    end else if (state_q[i] == S_REQ) begin
                        wait_d[i] = wait_inc[i];
                        if ({24'd0, wait_inc[i]} >= WAIT_LIMIT) tmo_d[i] = 1'b1;
                    end
                end
                S_REL: begin
                    if (!gnt[i]) begin
                        done_d[i] = 1'b1;
                        wait_d[i] = '0;
                        if (pend_v_q[i]) begin
                            state_d[i]  = S_REQ;
                            cnt_d[i]    = pend_len_q[i];
                            pend_v_d[i] = 1'b0;
                        end else if (bus.start[i]) begin
                            // Store-then-consume collapsed: an empty slot and
                            // a start on the exit cycle launch directly.
                            state_d[i] = S_REQ;
                            cnt_d[i]   = len_eff[i];
                        end else begin
                            state_d[i] = S_IDLE;
                        end
                    end
                end
            endcase

            if (bus.start[i] && (state_q[i] != S_IDLE) &&
                !(rel_exit[i] && !pend_v_q[i])) begin
                if (!pend_v_q[i] || rel_exit[i]) begin
                    pend_v_d[i]   = 1'b1;
                    pend_len_d[i] = len_eff[i];
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end

            req_d[i] = (state_d[i] == S_REQ) || (state_d[i] == S_XFER);
        end
    end

    // Outputs.
    always_comb begin
        bus.req_0 = req_q[0];
        bus.req_1 = req_q[1];
        bus.req_2 = req_q[2];
        bus.req_3 = req_q[3];
        bus.done  = done_q;
        bus.ovf   = ovf_q;
        bus.tmo   = tmo_q;
        bus.spur  = spur_q;
        bus.busy  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            bus.busy[i] = (state_q[i] != S_IDLE);
        end
    end

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Self-checking bench for arb_req_ctrl: a table of per-cycle vectors fed
// through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_arb_req_ctrl;

    typedef struct packed {
        logic [3:0] start;
        logic [3:0] len;
        logic [3:0] gnt;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] busy;
        logic [3:0] ovf;
        logic [3:0] tmo;
        logic [3:0] spur;
    } vec_t;

    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl [18];
    vec_t sb_q [$];

    arb_req_ctrl_if bus ();

    arb_req_ctrl #(.WAIT_LIMIT(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    function automatic logic [3:0] reqv();
        return {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic set_len(input logic [3:0] l);
        bus.len_0 = l;
        bus.len_1 = l;
        bus.len_2 = l;
        bus.len_3 = l;
    endtask

    task automatic cyc(input logic [3:0] s, input logic [3:0] g);
        bus.start = s;
        {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0} = g;
        @(posedge clock);
        #1;
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        sb_q.push_back(v);
        set_len(v.len);
        cyc(v.start, v.gnt);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue, required one entry");
        end else begin
            e = sb_q.pop_front();
            chk("tbl.req",  reqv(),   e.req);
            chk("tbl.done", bus.done, e.done);
            chk("tbl.busy", bus.busy, e.busy);
            chk("tbl.ovf",  bus.ovf,  e.ovf);
            chk("tbl.tmo",  bus.tmo,  e.tmo);
            chk("tbl.spur", bus.spur, e.spur);
        end
    endtask

    initial begin
        //          start    len    gnt      req      done     busy     ovf  tmo  spur
        // Agent 0, len 3: three beats, REL held while gnt high, done after drop.
        tbl[0]  = '{4'b0001, 4'd3, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'b0000};
        tbl[1]  = '{4'b0000, 4'd3, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'b0000};
        tbl[2]  = '{4'b0000, 4'd3, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'b0000};
        tbl[3]  = '{4'b0000, 4'd3, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'b0000};
        tbl[4]  = '{4'b0000, 4'd3, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'd0, 4'd0, 4'b0000};
        tbl[5]  = '{4'b0000, 4'd3, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'd0, 4'd0, 4'b0000};
        tbl[6]  = '{4'b0000, 4'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0000};
        // Agent 1, len 0 treated as a single beat.
        tbl[7]  = '{4'b0010, 4'd0, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'd0, 4'd0, 4'b0000};
        tbl[8]  = '{4'b0000, 4'd0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'd0, 4'd0, 4'b0000};
        tbl[9]  = '{4'b0000, 4'd0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'd0, 4'd0, 4'b0000};
        tbl[10] = '{4'b0000, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0000};
        // Grant to idle agent 1 sets sticky spur.
        tbl[11] = '{4'b0000, 4'd0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0010};
        tbl[12] = '{4'b0000, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0010};
        // All four agents start together, len 2.
        tbl[13] = '{4'b1111, 4'd2, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'd0, 4'd0, 4'b0010};
        tbl[14] = '{4'b0000, 4'd2, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'd0, 4'd0, 4'b0010};
        tbl[15] = '{4'b0000, 4'd2, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'd0, 4'd0, 4'b0010};
        tbl[16] = '{4'b0000, 4'd2, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'd0, 4'd0, 4'b0010};
        tbl[17] = '{4'b0000, 4'd2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0010};

        reset = 1'b1;
        set_len(4'd0);
        cyc(4'b0000, 4'b0000);
        cyc(4'b1111, 4'b1111);
        chk("rst.req",  reqv(),   4'b0000);
        chk("rst.done", bus.done, 4'b0000);
        chk("rst.busy", bus.busy, 4'b0000);
        chk("rst.spur", bus.spur, 4'b0000);
        reset = 1'b0;
        cyc(4'b0000, 4'b0000);

        for (int i = 0; i < 18; i++) step(tbl[i]);

        // Pending slot and overflow on agent 2, len 4.
        set_len(4'd4);
        cyc(4'b0100, 4'b0000);
        chk("pend.req_first", reqv() & 4'b0100, 4'b0100);
        cyc(4'b0100, 4'b0000);
        chk("pend.no_ovf", bus.ovf, 4'b0000);
        cyc(4'b0100, 4'b0000);
        chk("pend.ovf", bus.ovf, 4'b0100);
        chk("pend.req_hold", reqv() & 4'b0100, 4'b0100);
        for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0100);
        chk("pend.req_beat3", reqv() & 4'b0100, 4'b0100);
        cyc(4'b0000, 4'b0100);
        chk("pend.req_rel", reqv() & 4'b0100, 4'b0000);
        chk("pend.busy_rel", bus.busy & 4'b0100, 4'b0100);
        cyc(4'b0000, 4'b0000);
        chk("pend.done1", bus.done, 4'b0100);
        chk("pend.req_b2b", reqv() & 4'b0100, 4'b0100);
        cyc(4'b0000, 4'b0000);
        chk("pend.done_one", bus.done, 4'b0000);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 4'b0100);
        chk("pend.req_rel2", reqv() & 4'b0100, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("pend.done2", bus.done, 4'b0100);
        chk("pend.idle", bus.busy, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("pend.ovf_sticky", bus.ovf, 4'b0100);

        // Grant timeout on agent 3 at exactly 64 ungranted cycles.
        set_len(4'd1);
        cyc(4'b1000, 4'b0000);
        for (int i = 0; i < 63; i++) cyc(4'b0000, 4'b0000);
        chk("tmo.at63", bus.tmo, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("tmo.at64", bus.tmo, 4'b1000);
        chk("tmo.req_high", reqv() & 4'b1000, 4'b1000);
        cyc(4'b0000, 4'b1000);
        chk("tmo.req_rel", reqv() & 4'b1000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("tmo.done", bus.done, 4'b1000);
        chk("tmo.sticky", bus.tmo, 4'b1000);

        // Lost grant mid-burst on agent 0, len 5.
        set_len(4'd5);
        cyc(4'b0001, 4'b0000);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0000);
        chk("lost.req_hold1", reqv() & 4'b0001, 4'b0001);
        cyc(4'b0000, 4'b0000);
        chk("lost.req_hold2", reqv() & 4'b0001, 4'b0001);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0001);
        chk("lost.req_beat4", reqv() & 4'b0001, 4'b0001);
        cyc(4'b0000, 4'b0001);
        chk("lost.req_beat5", reqv() & 4'b0001, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("lost.done", bus.done, 4'b0001);

        // Reset during XFER on agent 1, grants high throughout reset.
        set_len(4'd3);
        cyc(4'b0010, 4'b0000);
        cyc(4'b0000, 4'b0010);
        chk("rstx.req_xfer", reqv() & 4'b0010, 4'b0010);
        reset = 1'b1;
        cyc(4'b0000, 4'b1111);
        chk("rstx.req",  reqv(),   4'b0000);
        chk("rstx.done", bus.done, 4'b0000);
        chk("rstx.busy", bus.busy, 4'b0000);
        chk("rstx.ovf",  bus.ovf,  4'b0000);
        chk("rstx.tmo",  bus.tmo,  4'b0000);
        chk("rstx.spur", bus.spur, 4'b0000);
        reset = 1'b0;
        cyc(4'b0000, 4'b0000);
        chk("rstx.done_after", bus.done, 4'b0000);
        chk("rstx.spur_after", bus.spur, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
